// File: rtl/fpga_pkg.sv
// fpga_pkg: parameters and status types shared by the execution core and the input channel.
package fpga_pkg;
    localparam int MemoryElementWidth = 12;
    localparam int NIn = 3;
    localparam int CountWidth = $clog2(NIn + 1);
    localparam int PtrWidth = (NIn > 1) ? $clog2(NIn) : 1;
    typedef struct packed {
        logic underflow;
        logic overflow;
    } in_channel_status_t;
    function automatic logic [PtrWidth-1:0] ptr_next(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(NIn - 1)) ? '0 : p + 1'b1;
    endfunction
endpackage

// File: rtl/in_channel_ram.sv
// in_channel_ram: NIn-deep channel storage with one synchronous write port and one asynchronous read port.
module in_channel_ram
    import fpga_pkg::*;
(
    input  logic                          clock,
    input  logic                          i_we,
    input  logic [PtrWidth-1:0]           i_waddr,
    input  logic [MemoryElementWidth-1:0] i_wdata,
    input  logic [PtrWidth-1:0]           i_raddr,
    output logic [MemoryElementWidth-1:0] o_rdata
);
    logic [MemoryElementWidth-1:0] r_mem [NIn];
    always_ff @(posedge clock) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end
    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/in_channel_fifo.sv
// in_channel_fifo: circular input buffer between an external valid/ready producer and the core's inSize/in instructions.
module in_channel_fifo
    import fpga_pkg::*;
(
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          pushValid,
    input  logic [MemoryElementWidth-1:0] pushData,
    output logic                          pushReady,
    input  logic                          popEn,
    output logic [MemoryElementWidth-1:0] popData,
    output logic [CountWidth-1:0]         size,
    output logic                          popValid,
    output logic [MemoryElementWidth-1:0] popDataQ,
    output logic                          underflow,
    output logic                          overflow,
    output logic [15:0]                   totalIn
);
    logic [PtrWidth-1:0]           r_head;
    logic [PtrWidth-1:0]           r_tail;
    logic [CountWidth-1:0]         r_size;
    logic                          r_pop_valid;
    logic [MemoryElementWidth-1:0] r_pop_data_q;
    logic [15:0]                   r_total_in;
    in_channel_status_t            r_status;
    logic                          w_push;
    logic                          w_pop;
    logic                          w_empty;
    logic [MemoryElementWidth-1:0] w_head_data;
    in_channel_ram u_ram (
        .clock   (clock),
        .i_we    (w_push),
        .i_waddr (r_tail),
        .i_wdata (pushData),
        .i_raddr (r_head),
        .o_rdata (w_head_data)
    );
    // Ready depends only on occupancy so the core never loops combinationally into the producer.
    assign pushReady = (r_size != CountWidth'(NIn));
    assign w_empty   = (r_size == '0);
    assign w_push    = pushValid && pushReady;
    assign w_pop     = popEn && !w_empty;
    always_ff @(posedge clock) begin
        if (reset) begin
            r_head       <= '0;
            r_tail       <= '0;
            r_size       <= '0;
            r_pop_valid  <= 1'b0;
            r_pop_data_q <= '0;
            r_total_in   <= '0;
            r_status     <= '0;
        end else begin
            if (w_push) r_tail <= ptr_next(r_tail);
            if (w_pop) begin
                r_head       <= ptr_next(r_head);
                r_pop_data_q <= w_head_data;
            end
            r_pop_valid        <= w_pop;
            r_size             <= r_size + CountWidth'(w_push) - CountWidth'(w_pop);
            r_total_in         <= r_total_in + 16'(w_push);
            r_status.underflow <= r_status.underflow | (popEn && w_empty);
            r_status.overflow  <= r_status.overflow | (pushValid && !pushReady);
        end
    end
    assign popData   = w_head_data;
    assign size      = r_size;
    assign popValid  = r_pop_valid;
    assign popDataQ  = r_pop_data_q;
    assign underflow = r_status.underflow;
    assign overflow  = r_status.overflow;
    assign totalIn   = r_total_in;
endmodule

// File: tb/tb_in_channel_fifo.sv
// tb_in_channel_fifo: directed vectors for in_channel_fifo with hand-computed expectations.
module tb_in_channel_fifo;
    import fpga_pkg::*;
    logic                          clock = 1'b0;
    logic                          reset;
    logic                          pushValid;
    logic [MemoryElementWidth-1:0] pushData;
    logic                          pushReady;
    logic                          popEn;
    logic [MemoryElementWidth-1:0] popData;
    logic [CountWidth-1:0]         size;
    logic                          popValid;
    logic [MemoryElementWidth-1:0] popDataQ;
    logic                          underflow;
    logic                          overflow;
    logic [15:0]                   totalIn;
    int n_cmp = 0;
    int n_bad = 0;
    int q[$];
    in_channel_fifo dut (
        .clock     (clock),
        .reset     (reset),
        .pushValid (pushValid),
        .pushData  (pushData),
        .pushReady (pushReady),
        .popEn     (popEn),
        .popData   (popData),
        .size      (size),
        .popValid  (popValid),
        .popDataQ  (popDataQ),
        .underflow (underflow),
        .overflow  (overflow),
        .totalIn   (totalIn)
    );
    always #5 clock = ~clock;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask
    initial begin
        reset = 1'b1; pushValid = 1'b0; pushData = '0; popEn = 1'b0;
        step();
        reset = 1'b0;
        check("rst_size", 32'(size), 0);
        check("rst_ready", 32'(pushReady), 1);
        check("rst_pop_valid", 32'(popValid), 0);
        check("rst_pop_data_q", 32'(popDataQ), 0);
        check("rst_flags", {30'd0, underflow, overflow}, 0);
        check("rst_total", 32'(totalIn), 0);
        // 1: fill
        pushValid = 1'b1;
        pushData = 12'd33; step(); check("t1_size1", 32'(size), 1); check("t1_head", 32'(popData), 33);
        pushData = 12'd22; step(); check("t1_size2", 32'(size), 2);
        pushData = 12'd11; step(); check("t1_size3", 32'(size), 3);
        pushValid = 1'b0;
        check("t1_ready", 32'(pushReady), 0);
        check("t1_total", 32'(totalIn), 3);
        check("t1_no_ovf", 32'(overflow), 0);
        // 2: drain, size before each pop
        q = '{33, 22, 11};
        for (int i = 0; i < 3; i++) begin
            check("t2_size", 32'(size), 32'(3 - i));
            check("t2_head", 32'(popData), 32'(q[i]));
            popEn = 1'b1;
            step();
            check("t2_pop_valid", 32'(popValid), 1);
            check("t2_pop_data_q", 32'(popDataQ), 32'(q[i]));
        end
        check("t2_size_end", 32'(size), 0);
        // 3: underflow
        step();
        check("t3_pop_valid", 32'(popValid), 0);
        check("t3_underflow", 32'(underflow), 1);
        check("t3_size", 32'(size), 0);
        check("t3_hold_q", 32'(popDataQ), 11);
        popEn = 1'b0;
        // 4: full, push+pop together
        pushValid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            pushData = 12'(i);
            step();
        end
        check("t4_full", 32'(size), 3);
        pushData = 12'd44; popEn = 1'b1;
        step();
        pushValid = 1'b0; popEn = 1'b0;
        check("t4_pop_valid", 32'(popValid), 1);
        check("t4_pop_data_q", 32'(popDataQ), 1);
        check("t4_overflow", 32'(overflow), 1);
        check("t4_size", 32'(size), 2);
        check("t4_total", 32'(totalIn), 6);
        check("t4_head", 32'(popData), 2);
        // 5: streaming through a half-full buffer across pointer wrap
        q = '{2, 3};
        for (int k = 0; k < 10; k++) begin
            pushValid = 1'b1; popEn = 1'b1; pushData = 12'(100 + k);
            q.push_back(100 + k);
            step();
            check("t5_pop_data_q", 32'(popDataQ), 32'(q.pop_front()));
            check("t5_size", 32'(size), 2);
        end
        check("t5_total", 32'(totalIn), 16);
        check("t5_head", 32'(popData), 32'(q[0]));
        // 6: reset wins over active traffic
        reset = 1'b1;
        step();
        check("t6_size", 32'(size), 0);
        check("t6_flags", {30'd0, underflow, overflow}, 0);
        check("t6_pop_valid", 32'(popValid), 0);
        check("t6_pop_data_q", 32'(popDataQ), 0);
        check("t6_total", 32'(totalIn), 0);
        reset = 1'b0; pushValid = 1'b0; popEn = 1'b0;
        step();
        check("t6_idle_size", 32'(size), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
